vga_timing_gen: RTL

Parametrised VGA timing and tick generator for the Arkanoid display path. It runs from the single 50 MHz board clock (clk_in) and generates a pixel clock-enable internally, so no divided clock is created. It outputs hs/vs, pixel coordinates, a video_on flag, a per-frame pulse and a speed-programmable game tick. It replaces the separate clk_25M/CLK dividers and the fixed-640x480 sync generator, and feeds the display and game-logic blocks.

---
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Bundle between the VGA timing generator and its consumers (display, game logic).
// master = the timing generator, slave = a consumer that programs speed/pause.
interface vga_timing_gen_if #(
  parameter int SPEED_W = 4
);
  logic [SPEED_W-1:0] speed;
  logic               pause;
  logic               pix_ce;
  logic [9:0]         h_count;
  logic [9:0]         v_count;
  logic               hs;
  logic               vs;
  logic               video_on;
  logic               frame_tick;
  logic               game_tick;
  logic [2:0]         rgb;

  modport master (
    input  speed, pause,
    output pix_ce, h_count, v_count, hs, vs, video_on, frame_tick, game_tick, rgb
  );

  modport slave (
    output speed, pause,
    input  pix_ce, h_count, v_count, hs, vs, video_on, frame_tick, game_tick, rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing, frame tick and programmable game tick from one clock via a pixel enable.
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int SPEED_W  = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic VS_ON  = (VS_POL != 0);
  // With a divide of 1 the enable is permanently high, including straight out of reset.
  localparam logic CE_RST = (PIX_DIV == 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               pix_ce_q, pix_ce_d;
  logic [9:0]         h_count_q, h_count_d;
  logic [9:0]         v_count_q, v_count_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               video_on_q, video_on_d;
  logic               frame_tick_q, frame_tick_d;
  logic               game_tick_q, game_tick_d;
  logic [SPEED_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               frame_start;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_ce_d  = (div_cnt_d == DIV_LAST);

    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (pix_ce_q) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end
    frame_start = pix_ce_q && (h_count_q == H_LAST) && (v_count_q == V_LAST);

    // Decode from the next counter values so the registered flags line up with the counters.
    hs_d       = ((h_count_d >= HS_START) && (h_count_d <= HS_END)) ? HS_ON : ~HS_ON;
    vs_d       = ((v_count_d >= VS_START) && (v_count_d <= VS_END)) ? VS_ON : ~VS_ON;
    video_on_d = (h_count_d < H_ACT) && (v_count_d < V_ACT);

    frame_tick_d = frame_start;
    game_tick_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    if (frame_start && !vga.pause) begin
      // >= rather than == so lowering speed below the running count fires at the next frame.
      if (frame_cnt_q >= vga.speed) begin
        game_tick_d = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt_q    <= '0;
      pix_ce_q     <= CE_RST;
      h_count_q    <= '0;
      v_count_q    <= '0;
      hs_q         <= ~HS_ON;
      vs_q         <= ~VS_ON;
      video_on_q   <= 1'b1;
      frame_tick_q <= 1'b0;
      game_tick_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pix_ce_q     <= pix_ce_d;
      h_count_q    <= h_count_d;
      v_count_q    <= v_count_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
      game_tick_q  <= game_tick_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign vga.pix_ce     = pix_ce_q;
  assign vga.h_count    = h_count_q;
  assign vga.v_count    = v_count_q;
  assign vga.hs         = hs_q;
  assign vga.vs         = vs_q;
  assign vga.video_on   = video_on_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.game_tick  = game_tick_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [2:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = video_on_d ? 3'(h_count_d / BAR_W) : 3'b000;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vga.rgb = rgb_q;
`else
  assign vga.rgb = 3'b000;
`endif
endmodule
